// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the req_arbiter slice.
// Holds the FSM state enum and default N / MAX_HOLD values.
package arb_pkg;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/req_arbiter_if.sv
// req_arbiter_if: requester-side bundle (req/mode/done in; gnt/gnt_id/
// gnt_valid/preempt out). master = requesters, slave = arbiter.
interface req_arbiter_if
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   req;
  logic           mode;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           preempt;

  modport master (
    output req, mode, done,
    input  gnt, gnt_id, gnt_valid, preempt
  );

  modport slave (
    input  req, mode, done,
    output gnt, gnt_id, gnt_valid, preempt
  );

endinterface

// File: rtl/arb_prio_pick.sv
// arb_prio_pick: combinational winner select. In: req, last_id, mode.
// Out: winner (fixed: highest set bit; rr: last_id-1 downward, wrapping), any_req.
module arb_prio_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_id,
  input  logic           mode,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  function automatic logic [IDW-1:0] rr_idx(
    input logic [IDW-1:0] last,
    input int             k
  );
    int j;
    j = int'(last) - k;
    if (j < 0) j = j + N;
    return IDW'(j);
  endfunction

  always_comb begin
    winner  = '0;
    any_req = |req;
    if (!mode) begin
      for (int i = 0; i < N; i++)
        if (req[i]) winner = IDW'(i);
    end else begin
      // Walk from the far end so the closest hit to last_id-1 wins.
      for (int k = N; k >= 1; k--)
        if (req[rr_idx(last_id, k)])
          winner = rr_idx(last_id, k);
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: N-way sequencing arbiter, fixed or round-robin, registered grant.
// Ports: clk, rst_n (sync, active-low), bus (req_arbiter_if.slave).
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int IDW      = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  req_arbiter_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  arb_state_t     state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [IDW-1:0] last_q, last_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           vld_q, vld_d;
  logic           pre_q, pre_d;

  logic [IDW-1:0] win;
  logic           any_req;
  logic           own_req;
  logic           oth_req;
  logic           timeout;
  logic           leave;

  arb_prio_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (bus.req),
    .last_id (last_q),
    .mode    (bus.mode),
    .winner  (win),
    .any_req (any_req)
  );

  // Owner identity comes from the one-hot grant, so no index
  // ever reaches past N-1 for non power-of-two N.
  always_comb begin
    own_req = |(bus.req & gnt_q);
    oth_req = |(bus.req & ~gnt_q);
    timeout = bus.mode && (hold_q == HOLD_LIM) && oth_req;
    leave   = bus.done || !own_req || timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (leave) state_d = RELEASE;
      RELEASE: state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    last_d = last_q;
    gnt_d  = gnt_q;
    id_d   = id_q;
    vld_d  = vld_q;
    pre_d  = 1'b0;
    unique case (state_q)
      IDLE, RELEASE: begin
        gnt_d = '0;
        vld_d = 1'b0;
        if (any_req) begin
          gnt_d[win] = 1'b1;
          id_d       = win;
          vld_d      = 1'b1;
          hold_d     = '0;
        end
      end
      GRANT: begin
        if (leave) begin
          gnt_d  = '0;
          vld_d  = 1'b0;
          last_d = id_q;
          hold_d = '0;
          // Only a pure timeout counts as pre-emption.
          pre_d  = timeout && !bus.done && own_req;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d  = '0;
        vld_d  = 1'b0;
        hold_d = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = vld_q;
  assign bus.preempt   = pre_q;

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: vector table, corner sequences and random run
// against an owner/held-cycles reference model of req_arbiter.
module tb_req_arbiter;
  import arb_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  req_arbiter_if #(.N(N)) bus();

  req_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  bit m_pre   = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  typedef struct {
    bit       rst_n;
    logic [3:0] req;
    bit       mode;
    bit       done;
    logic [3:0] gnt;
    int       id;
    bit       pre;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input bit md,
                              input int last);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--)
        if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++)
        if (r[(last - k + N) % N]) return (last - k + N) % N;
    end
    return -1;
  endfunction

  task automatic drive(input bit r, input logic [3:0] q,
                       input bit m, input bit d);
    rst_n    = r;
    bus.req  = q;
    bus.mode = m;
    bus.done = d;
  endtask

  task automatic step();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    bit own;
    bit oth;
    @(posedge clk);
    r = bus.req;
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 0;
      m_pre   = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner >= 0) begin
        own = r[m_owner];
        oth = (r & ~(N'(1) << m_owner)) != '0;
        if (bus.done || !own ||
            (bus.mode && m_held >= MAX_HOLD && oth)) begin
          m_pre   = !bus.done && own;
          m_last  = m_owner;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else begin
        m_owner = pick(r, bus.mode, m_last);
        m_held  = 1;
      end
    end
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("model_gnt", bus.gnt, eg);
    chk("model_valid", bus.gnt_valid, m_owner >= 0);
    chk("model_preempt", bus.preempt, m_pre);
    if (m_owner >= 0) chk("model_gnt_id", bus.gnt_id, m_owner);
    chk("onehot", $onehot0(bus.gnt), 1);
    chk("zero_gap",
        prev_gnt != '0 && bus.gnt != '0 && prev_gnt != bus.gnt, 0);
    if (bus.gnt_valid)
      chk("id_vs_gnt", bus.gnt, N'(1) << bus.gnt_id);
    prev_gnt = bus.gnt;
  endtask

  initial begin
    // rst, req, mode, done -> gnt, id (-1 = unchecked), preempt
    tbl.push_back('{0, 4'b0000, 0, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0101, 0, 0, 4'b0100,  2, 0});
    tbl.push_back('{1, 4'b0001, 0, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0001, 0, 0, 4'b0001,  0, 0});
    tbl.push_back('{1, 4'b0000, 0, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b1111, 1, 0, 4'b1000,  3, 0});
    tbl.push_back('{1, 4'b1111, 1, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b1111, 1, 0, 4'b0100,  2, 0});
    tbl.push_back('{1, 4'b1111, 1, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b1111, 1, 0, 4'b0010,  1, 0});
    tbl.push_back('{1, 4'b1111, 1, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b1111, 1, 0, 4'b0001,  0, 0});
    tbl.push_back('{1, 4'b1111, 1, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b1111, 1, 0, 4'b1000,  3, 0});
    tbl.push_back('{1, 4'b0000, 1, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0000, 1, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0110, 0, 0, 4'b0100,  2, 0});
    tbl.push_back('{1, 4'b0010, 0, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0010, 0, 0, 4'b0010,  1, 0});
    tbl.push_back('{0, 4'b0010, 0, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b1111, 1, 0, 4'b1000,  3, 0});
    tbl.push_back('{1, 4'b0000, 1, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0000, 1, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0100, 0, 0, 4'b0100,  2, 0});
    tbl.push_back('{1, 4'b0000, 0, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0000, 0, 0, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0000, 0, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0001, 0, 1, 4'b0001,  0, 0});
    tbl.push_back('{1, 4'b0001, 0, 0, 4'b0001,  0, 0});
    tbl.push_back('{1, 4'b0000, 0, 1, 4'b0000, -1, 0});
    tbl.push_back('{1, 4'b0000, 0, 0, 4'b0000, -1, 0});

    drive(0, 4'b0000, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].mode, tbl[i].done);
      step();
      chk("tbl_gnt", bus.gnt, tbl[i].gnt);
      chk("tbl_valid", bus.gnt_valid, tbl[i].gnt != 4'b0000);
      chk("tbl_preempt", bus.preempt, tbl[i].pre);
      if (tbl[i].id >= 0) chk("tbl_gnt_id", bus.gnt_id, tbl[i].id);
    end

    // Round-robin hold limit: owner 3 keeps the bus for MAX_HOLD cycles.
    drive(1, 4'b1001, 1, 0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step();
      chk("hold_gnt", bus.gnt, 4'b1000);
      chk("hold_pre", bus.preempt, 0);
    end
    step();
    chk("timeout_gnt", bus.gnt, 4'b0000);
    chk("timeout_pre", bus.preempt, 1);
    step();
    chk("after_to_gnt", bus.gnt, 4'b0001);
    chk("after_to_pre", bus.preempt, 0);
    drive(1, 4'b0000, 1, 1);
    step();
    drive(1, 4'b0000, 0, 0);
    step();

    // Fixed mode ignores the hold limit.
    drive(1, 4'b1000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fixed_hold_gnt", bus.gnt, 4'b1000);
      chk("fixed_hold_pre", bus.preempt, 0);
    end
    drive(1, 4'b0000, 0, 0);
    step();
    chk("fixed_rel_gnt", bus.gnt, 4'b0000);
    step();

    // Random traffic with requests that tend to persist.
    for (int c = 0; c < 10000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
